runled_monitor: RTL and testbench



---
 rtl/runled_if.sv | 10 +
 rtl/runled_monitor.sv | 139 +++++++++++++
 tb/tb_runled_monitor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/runled_if.sv
// runled_if: LED bus carried from the running-light driver to its monitor.
// Ports: led_in (driven by master, sampled by slave).
interface runled_if #(
    parameter int WIDTH = 12
);
    logic [WIDTH-1:0] led_in;

    modport master (output led_in);
    modport slave  (input  led_in);
endinterface

// File: rtl/runled_monitor.sv
// runled_monitor: checks a one-hot left-rotating LED bus for shape, order and step period.
// Ports: clk, rst_n, bus.led_in, clr in; locked, step_pulse, step_cnt, err_onehot/order/period out.
module runled_monitor #(
    parameter int WIDTH   = 12,
    parameter int TIME_1S = 50000000,
    parameter int TOL     = 2,
    parameter int CNT_W   = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    runled_if.slave     bus,
    input  logic        clr,
    output logic        locked,
    output logic        step_pulse,
    output logic [15:0] step_cnt,
    output logic        err_onehot,
    output logic        err_order,
    output logic        err_period
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, FAULT} state_e;

    // cnt holds interval-1 at a change, so the window is centred on TIME_1S-1
    localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(TIME_1S - 1 - TOL);
    localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(TIME_1S - 1 + TOL);
    localparam logic [CNT_W-1:0] T_OUT  = CNT_W'(TIME_1S + TOL);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      step_cnt_q, step_cnt_d;
    logic             pulse_q, pulse_d;
    logic             locked_q, locked_d;
    logic             e_oh_q, e_oh_d;
    logic             e_ord_q, e_ord_d;
    logic             e_per_q, e_per_d;

    logic [WIDTH-1:0] led, nxt;
    logic             chg, one_hot, in_win;
    logic             f_oh, f_ord, f_per, fail;

    assign led     = bus.led_in;
    assign chg     = (led != led_q);
    assign nxt     = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
    assign one_hot = (led != '0) && ((led & (led - WIDTH'(1))) == '0);
    assign in_win  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);

    assign f_oh  = !one_hot;
    assign f_ord = chg && (led != nxt);
    // a change is judged on its interval; no change is judged on timeout
    assign f_per = chg ? !in_win : (cnt_q == T_OUT);
    assign fail  = f_oh || f_ord || f_per;

    always_comb begin
        led_d      = led;
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        pulse_d    = 1'b0;
        e_oh_d     = e_oh_q;
        e_ord_d    = e_ord_q;
        e_per_d    = e_per_q;

        if (chg)
            cnt_d = '0;
        else if (cnt_q == '1)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (chg && one_hot)
                    state_d = ACQ;
            end
            ACQ, TRACK: begin
                if (fail) begin
                    state_d = FAULT;
                    e_oh_d  = e_oh_q  | f_oh;
                    e_ord_d = e_ord_q | f_ord;
                    e_per_d = e_per_q | f_per;
                end else if (chg) begin
                    if (state_q == ACQ) begin
                        state_d = TRACK;
                    end else begin
                        pulse_d    = 1'b1;
                        step_cnt_d = step_cnt_q + 16'd1;
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: state_d = IDLE;
        endcase

        if (clr) begin
            state_d    = IDLE;
            step_cnt_d = '0;
            pulse_d    = 1'b0;
            e_oh_d     = 1'b0;
            e_ord_d    = 1'b0;
            e_per_d    = 1'b0;
        end

        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            led_q      <= '0;
            cnt_q      <= '0;
            step_cnt_q <= '0;
            pulse_q    <= 1'b0;
            locked_q   <= 1'b0;
            e_oh_q     <= 1'b0;
            e_ord_q    <= 1'b0;
            e_per_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
            step_cnt_q <= step_cnt_d;
            pulse_q    <= pulse_d;
            locked_q   <= locked_d;
            e_oh_q     <= e_oh_d;
            e_ord_q    <= e_ord_d;
            e_per_q    <= e_per_d;
        end
    end

    assign locked     = locked_q;
    assign step_pulse = pulse_q;
    assign step_cnt   = step_cnt_q;
    assign err_onehot = e_oh_q;
    assign err_order  = e_ord_q;
    assign err_period = e_per_q;

endmodule

// File: tb/tb_runled_monitor.sv
// tb_runled_monitor: directed checks of runled_monitor with TIME_1S=10, TOL=1.
// Drives the LED bus through lock, wrap, window edges, timeout, order/one-hot faults, clr and reset.
module tb_runled_monitor;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        locked;
    logic        step_pulse;
    logic [15:0] step_cnt;
    logic        err_onehot;
    logic        err_order;
    logic        err_period;

    int          checks;
    int          fails;
    logic [15:0] exp_cnt;

    runled_if #(.WIDTH(12)) bus_if ();

    runled_monitor #(
        .WIDTH  (12),
        .TIME_1S(10),
        .TOL    (1),
        .CNT_W  (27)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .clr       (clr),
        .locked    (locked),
        .step_pulse(step_pulse),
        .step_cnt  (step_cnt),
        .err_onehot(err_onehot),
        .err_order (err_order),
        .err_period(err_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_errs(input string tag, input logic oh,
                            input logic ord, input logic per);
        chk({tag, ".onehot"}, err_onehot, oh);
        chk({tag, ".order"},  err_order,  ord);
        chk({tag, ".period"}, err_period, per);
    endtask

    // set a new bus value, check the response one clock later, hold n clocks total
    task automatic step_to(input logic [11:0] v, input int n,
                           input logic p, input logic l);
        bus_if.led_in = v;
        hold(1);
        if (p) exp_cnt = exp_cnt + 16'd1;
        chk($sformatf("pulse@%03h", v),  step_pulse, p);
        chk($sformatf("locked@%03h", v), locked, l);
        chk($sformatf("cnt@%03h", v),    step_cnt, exp_cnt);
        hold(n - 1);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        exp_cnt = '0;
        chk_errs("clr", 1'b0, 1'b0, 1'b0);
        chk("clr.locked", locked, 1'b0);
        chk("clr.cnt", step_cnt, 16'd0);
    endtask

    initial begin
        checks  = 0;
        fails   = 0;
        exp_cnt = '0;
        rst_n   = 1'b0;
        clr     = 1'b0;
        bus_if.led_in = 12'h000;
        #12;
        chk("rst.locked", locked, 1'b0);
        chk("rst.pulse", step_pulse, 1'b0);
        chk("rst.cnt", step_cnt, 16'd0);
        chk_errs("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 1: acquire, lock on 2nd edge, pulses after
        step_to(12'h001, 10, 1'b0, 1'b0);
        step_to(12'h002, 10, 1'b0, 1'b1);
        step_to(12'h004, 10, 1'b1, 1'b1);
        step_to(12'h008, 10, 1'b1, 1'b1);
        step_to(12'h010, 10, 1'b1, 1'b1);
        chk("t1.cnt", step_cnt, 16'd3);
        chk_errs("t1", 1'b0, 1'b0, 1'b0);

        // 2: walk through the wrap 0x800 -> 0x001
        step_to(12'h020, 10, 1'b1, 1'b1);
        step_to(12'h040, 10, 1'b1, 1'b1);
        step_to(12'h080, 10, 1'b1, 1'b1);
        step_to(12'h100, 10, 1'b1, 1'b1);
        step_to(12'h200, 10, 1'b1, 1'b1);
        step_to(12'h400, 10, 1'b1, 1'b1);
        step_to(12'h800, 10, 1'b1, 1'b1);
        step_to(12'h001, 10, 1'b1, 1'b1);
        chk("t2.cnt", step_cnt, 16'd11);
        chk_errs("t2", 1'b0, 1'b0, 1'b0);

        // 3: intervals 9 and 11 accepted, then timeout
        step_to(12'h002, 9, 1'b1, 1'b1);
        step_to(12'h004, 11, 1'b1, 1'b1);
        step_to(12'h008, 1, 1'b1, 1'b1);
        chk("t3.cnt", step_cnt, 16'd14);
        hold(11);
        chk("t3.pre_to.locked", locked, 1'b1);
        chk("t3.pre_to.period", err_period, 1'b0);
        hold(1);
        chk("t3.to.locked", locked, 1'b0);
        chk_errs("t3.to", 1'b0, 1'b0, 1'b1);
        bus_if.led_in = 12'h010;
        hold(1);
        chk("t3.ign.pulse", step_pulse, 1'b0);
        chk("t3.ign.locked", locked, 1'b0);
        chk("t3.ign.cnt", step_cnt, 16'd14);
        chk_errs("t3.ign", 1'b0, 1'b0, 1'b1);

        // 4: order fault on time
        do_clr();
        step_to(12'h001, 10, 1'b0, 1'b0);
        step_to(12'h002, 10, 1'b0, 1'b1);
        step_to(12'h004, 10, 1'b1, 1'b1);
        bus_if.led_in = 12'h002;
        hold(1);
        chk("t4.locked", locked, 1'b0);
        chk("t4.pulse", step_pulse, 1'b0);
        chk_errs("t4", 1'b0, 1'b1, 1'b0);

        // 5: one-hot faults, two bits then zero
        do_clr();
        step_to(12'h001, 10, 1'b0, 1'b0);
        step_to(12'h002, 5, 1'b0, 1'b1);
        bus_if.led_in = 12'h006;
        hold(1);
        chk("t5a.onehot", err_onehot, 1'b1);
        chk("t5a.locked", locked, 1'b0);
        do_clr();
        step_to(12'h001, 10, 1'b0, 1'b0);
        step_to(12'h002, 5, 1'b0, 1'b1);
        bus_if.led_in = 12'h000;
        hold(1);
        chk("t5b.onehot", err_onehot, 1'b1);
        chk("t5b.locked", locked, 1'b0);

        // 6: clr with simultaneous change forces IDLE, relock needs two edges
        bus_if.led_in = 12'h001;
        clr = 1'b1;
        hold(1);
        clr = 1'b0;
        exp_cnt = '0;
        chk_errs("t6.clr", 1'b0, 1'b0, 1'b0);
        chk("t6.clr.locked", locked, 1'b0);
        chk("t6.clr.cnt", step_cnt, 16'd0);
        hold(9);
        step_to(12'h002, 10, 1'b0, 1'b0);
        step_to(12'h004, 10, 1'b0, 1'b1);
        step_to(12'h008, 5, 1'b1, 1'b1);

        // asynchronous reset mid-TRACK
        #3;
        rst_n = 1'b0;
        bus_if.led_in = 12'h001;
        #1;
        chk("arst.locked", locked, 1'b0);
        chk("arst.pulse", step_pulse, 1'b0);
        chk("arst.cnt", step_cnt, 16'd0);
        chk_errs("arst", 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;

        // interval 8 is just below the window in ACQ
        hold(8);
        bus_if.led_in = 12'h002;
        hold(1);
        chk("short.locked", locked, 1'b0);
        chk_errs("short", 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
